// File: rtl/pdm_cic_decimator_pkg.sv
// pdm_pkg: shared constants for the PDM microphone front end.
//   CIC_ORDER  number of integrator/comb pairs in the decimator
//   OUT_W      width of the PCM sample handed to the register block
//   acc_w()    accumulator width needed for lossless-modulo CIC arithmetic
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int OUT_W     = 16;

  // Bit growth of an N-stage CIC is N*log2(R); two extra bits cover the
  // sign of the +/-1 input and the +R^N full-scale corner.
  function automatic int acc_w(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// pdm_cic_decimator_if: sample hand-off between the PDM decimator and the
// register block.
//   sample_o        decimated PCM sample, two's complement
//   sample_valid_o  sample_o holds an unread sample
//   sample_ack_i    1-cycle pulse from the register block: sample consumed
//   overrun_clr_i   1-cycle pulse: clear the sticky overrun flag
//   overrun_o       a sample was overwritten before it was read
// master = decimator side, slave = register-block side.
interface pdm_cic_decimator_if;
  import pdm_pkg::*;

  logic [OUT_W-1:0] sample_o;
  logic             sample_valid_o;
  logic             sample_ack_i;
  logic             overrun_clr_i;
  logic             overrun_o;

  modport master (
    output sample_o, sample_valid_o, overrun_o,
    input  sample_ack_i, overrun_clr_i
  );

  modport slave (
    input  sample_o, sample_valid_o, overrun_o,
    output sample_ack_i, overrun_clr_i
  );

endinterface

// File: rtl/pdm_cic_decimator_clk_gen.sv
// pdm_clk_gen: microphone clock generator and PDM sample strobe.
//   clk, rst_n  system clock, async active-low reset
//   enable      0 holds pdm_clk_o low and the divider at zero
//   clk_div     half-period in clk cycles minus 1 (0 behaves as 1)
//   pdm_clk_o   microphone clock
//   strobe_o    high in the cycle pdm_clk_o falls (end of the high phase)
module pdm_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             pdm_clk_o,
  output logic             strobe_o
);

  logic [DIV_W-1:0] hc;
  logic [DIV_W-1:0] lim;
  logic [DIV_W-1:0] div_eff;
  logic             tc;

  assign div_eff  = (clk_div == '0) ? DIV_W'(1) : clk_div;
  assign tc       = (hc == lim);
  assign strobe_o = enable & tc & pdm_clk_o;

  // lim is a shadow of clk_div that only moves at a terminal count (or while
  // stopped), so a mid-phase change can never shorten the current phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc        <= '0;
      lim       <= DIV_W'(1);
      pdm_clk_o <= 1'b0;
    end else if (!enable) begin
      hc        <= '0;
      lim       <= div_eff;
      pdm_clk_o <= 1'b0;
    end else if (tc) begin
      hc        <= '0;
      lim       <= div_eff;
      pdm_clk_o <= ~pdm_clk_o;
    end else begin
      hc        <= hc + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM microphone front end. Generates the mic clock,
// samples the 1-bit stream and decimates it with a 3rd-order CIC filter.
//   clk, rst_n  system clock, async active-low reset
//   enable      1 = run, 0 = stop mic clock and flush the filter
//   clk_div     pdm_clk_o half-period in clk cycles minus 1
//   pdm_data_i  synchronized PDM bit
//   pdm_clk_o   microphone clock
//   smp         sample/valid/ack/overrun hand-off (master side)
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter int DECIM = 32,
  parameter int DIV_W = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [DIV_W-1:0]            clk_div,
  input  logic                        pdm_data_i,
  output logic                        pdm_clk_o,
  pdm_cic_decimator_if.master         smp
);

  localparam int ACC_W = acc_w(DECIM);
  localparam int DC_W  = $clog2(DECIM);

  if (DECIM != 32 && DECIM != 64) begin : g_bad_decim
    $error("pdm_cic_decimator: DECIM must be 32 or 64");
  end

  logic             strobe;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] i1, i2, i3;
  logic [ACC_W-1:0] d1, d2, d3;
  logic [ACC_W-1:0] c1, c2, c3;
  logic [DC_W-1:0]  dc;
  logic             comb_fire;
  logic             load;

  pdm_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .clk_div   (clk_div),
    .pdm_clk_o (pdm_clk_o),
    .strobe_o  (strobe)
  );

  // bit 1 -> +1, bit 0 -> -1 (all ones at ACC_W bits)
  assign x = pdm_data_i ? ACC_W'(1) : '1;

  assign c1 = i3 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;

  // Integrators and decimation counter. The comb runs one cycle after the
  // DECIM-th strobe so it sees i3 including that strobe's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      dc        <= '0;
      comb_fire <= 1'b0;
    end else if (!enable) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      dc        <= '0;
      comb_fire <= 1'b0;
    end else begin
      comb_fire <= strobe && (dc == DC_W'(DECIM - 1));
      if (strobe) begin
        i1 <= i1 + x;
        i2 <= i2 + i1;
        i3 <= i3 + i2;
        dc <= dc + DC_W'(1);
      end
      if (comb_fire) begin
        d1 <= i3;
        d2 <= c1;
        d3 <= c2;
      end
    end
  end

  assign load = comb_fire & enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp.sample_o       <= '0;
      smp.sample_valid_o <= 1'b0;
      smp.overrun_o      <= 1'b0;
    end else begin
      if (!enable) begin
        smp.sample_valid_o <= 1'b0;
      end else if (load) begin
        smp.sample_o       <= c3[ACC_W-1 -: OUT_W];
        smp.sample_valid_o <= 1'b1;
      end else if (smp.sample_ack_i) begin
        smp.sample_valid_o <= 1'b0;
      end

      // set has priority over clear
      if (load && smp.sample_valid_o && !smp.sample_ack_i) begin
        smp.overrun_o <= 1'b1;
      end else if (smp.overrun_clr_i) begin
        smp.overrun_o <= 1'b0;
      end
    end
  end

endmodule
